// File: rtl/neuromorphic_x1_wb_bank_router.sv
// Wishbone classic router: decodes a host request to one of NUM_BANKS X1 core banks or a local CSR block.
// One transaction is in flight at a time; bank waits are bounded by a cycle timeout.
module neuromorphic_x1_wb_bank_router #(
  parameter int          NUM_BANKS   = 4,
  parameter int          BANK_AW     = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_WORD    = 32'hBADC_0FFE
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic [31:0]               wbs_dat_o,
  output logic                      wbs_ack_o,
  output logic [NUM_BANKS-1:0]      bnk_cyc_o,
  output logic [NUM_BANKS-1:0]      bnk_stb_o,
  output logic                      bnk_we_o,
  output logic [3:0]                bnk_sel_o,
  output logic [31:0]               bnk_adr_o,
  output logic [31:0]               bnk_dat_o,
  input  logic [32*NUM_BANKS-1:0]   bnk_dat_i,
  input  logic [NUM_BANKS-1:0]      bnk_ack_i,
  output logic [1:0]                dbg_state
);
  // Handshake: host request accepted in IDLE when cyc&stb&hit; bank request held until bank ack or
  // timeout; host sees exactly one ack cycle in RESP unless it dropped cyc while the bank was busy.
  typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, RESP = 2'd2} state_t;
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

  state_t               state, state_nxt;
  logic [NUM_BANKS-1:0] ctrl, bnk_act, bnk_pick;
  logic                 st_timeout, st_decode;
  logic [2:0]           st_bank, cur_idx;
  logic [31:0]          txn_cnt, dat_sel, csr_rdata;
  logic [15:0]          tcnt;
  logic                 abort, hit, req, bank_tgt, csr_tgt, csr_wr, ack_sel, to_hit;
  logic [3:0]           idx;

  assign hit      = (wbs_adr_i[31:BANK_AW+4] == BASE_ADDR[31:BANK_AW+4]);
  assign idx      = wbs_adr_i[BANK_AW+3:BANK_AW];
  assign req      = (state == IDLE) && wbs_cyc_i && wbs_stb_i && hit;
  assign bank_tgt = |(bnk_pick & ctrl);
  assign csr_tgt  = (idx == 4'hF);
  assign csr_wr   = req && csr_tgt && wbs_we_i && (wbs_sel_i == 4'hF);
  assign to_hit   = ((tcnt + 16'd1) == TO_LIM);

  assign bnk_cyc_o = bnk_act;
  assign bnk_stb_o = bnk_act;

  // bnk_act is one-hot while forwarding, so an AND-OR mux ignores every other bank's ack and data.
  always_comb begin
    bnk_pick = '0;
    ack_sel  = 1'b0;
    dat_sel  = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      bnk_pick[i] = (idx == 4'(i));
      if (bnk_act[i]) begin
        ack_sel = ack_sel | bnk_ack_i[i];
        dat_sel = dat_sel | bnk_dat_i[32*i +: 32];
      end
    end
  end

  always_comb begin
    case (wbs_adr_i[3:2])
      2'd0:    csr_rdata = 32'(ctrl);
      2'd1:    csr_rdata = {21'd0, st_bank, 6'd0, st_decode, st_timeout};
      2'd2:    csr_rdata = txn_cnt;
      default: csr_rdata = {16'h5831, 8'(NUM_BANKS), 8'(BANK_AW)};
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = bank_tgt ? FWD : RESP;
      FWD:     if (ack_sel || to_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wbs_ack_o = (state == RESP) && !abort;
    dbg_state = state;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_dat_o  <= '0;
      bnk_act    <= '0;
      bnk_we_o   <= 1'b0;
      bnk_sel_o  <= '0;
      bnk_adr_o  <= '0;
      bnk_dat_o  <= '0;
      ctrl       <= '1;
      st_timeout <= 1'b0;
      st_decode  <= 1'b0;
      st_bank    <= '0;
      txn_cnt    <= '0;
      tcnt       <= '0;
      abort      <= 1'b0;
      cur_idx    <= '0;
    end else begin
      // CSR writes come first so a same-cycle error set overrides the W1C clear.
      if (csr_wr && wbs_adr_i[3:2] == 2'd0) ctrl <= wbs_dat_i[NUM_BANKS-1:0];
      if (csr_wr && wbs_adr_i[3:2] == 2'd1) begin
        if (wbs_dat_i[0]) st_timeout <= 1'b0;
        if (wbs_dat_i[1]) st_decode  <= 1'b0;
      end
      case (state)
        IDLE: begin
          abort <= 1'b0;
          if (req && bank_tgt) begin
            bnk_act   <= bnk_pick;
            bnk_we_o  <= wbs_we_i;
            bnk_sel_o <= wbs_sel_i;
            bnk_adr_o <= 32'(wbs_adr_i[BANK_AW-1:0]);
            bnk_dat_o <= wbs_dat_i;
            cur_idx   <= idx[2:0];
            tcnt      <= '0;
          end else if (req && csr_tgt) begin
            if (!wbs_we_i) wbs_dat_o <= csr_rdata;
          end else if (req) begin
            wbs_dat_o <= ERR_WORD;
            st_decode <= 1'b1;
            st_bank   <= idx[2:0];
          end
        end
        FWD: begin
          if (!wbs_cyc_i) abort <= 1'b1;
          tcnt <= tcnt + 16'd1;
          if (ack_sel) begin
            if (!bnk_we_o) wbs_dat_o <= dat_sel;
            bnk_act <= '0;
            txn_cnt <= txn_cnt + 32'd1;
          end else if (to_hit) begin
            bnk_act    <= '0;
            wbs_dat_o  <= ERR_WORD;
            st_timeout <= 1'b1;
            st_bank    <= cur_idx;
          end
        end
        default: ;
      endcase
      // Counter clear is applied last so it wins over a same-cycle increment.
      if (csr_wr && wbs_adr_i[3:2] == 2'd2) txn_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_neuromorphic_x1_wb_bank_router.sv
// Directed bench for the X1 bank router: host driver tasks, behavioural banks, and an ack scoreboard.
module tb_neuromorphic_x1_wb_bank_router;
  localparam int NB = 4;
  localparam logic [31:0] ERR = 32'hBADC_0FFE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0] wbs_sel_i = '0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic [31:0] wbs_dat_o;
  logic wbs_ack_o;
  logic [NB-1:0] bnk_cyc_o, bnk_stb_o;
  logic bnk_we_o;
  logic [3:0] bnk_sel_o;
  logic [31:0] bnk_adr_o, bnk_dat_o;
  logic [32*NB-1:0] bnk_dat_i = '0;
  logic [NB-1:0] bnk_ack_i = '0;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_last = '0;
  int dly[NB];
  logic [31:0] bdat[NB];
  int bcnt[NB];
  logic [31:0] cap_adr, cap_dat;
  logic [3:0] cap_sel;
  logic cap_we;

  neuromorphic_x1_wb_bank_router #(.NUM_BANKS(NB), .BANK_AW(12), .BASE_ADDR(32'h3000_0000),
                                   .TIMEOUT_CYC(8), .ERR_WORD(ERR)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
    .bnk_cyc_o(bnk_cyc_o), .bnk_stb_o(bnk_stb_o), .bnk_we_o(bnk_we_o),
    .bnk_sel_o(bnk_sel_o), .bnk_adr_o(bnk_adr_o), .bnk_dat_o(bnk_dat_o),
    .bnk_dat_i(bnk_dat_i), .bnk_ack_i(bnk_ack_i), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500us");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Behavioural banks: ack during the dly-th strobe cycle; dly 0 never acks.
  always @(negedge clk) begin
    for (int i = 0; i < NB; i++) begin
      bnk_dat_i[32*i +: 32] = bdat[i];
      if (bnk_stb_o[i]) begin
        bcnt[i]++;
        bnk_ack_i[i] = (dly[i] != 0) && (bcnt[i] == dly[i]);
      end else begin
        bcnt[i] = 0;
        bnk_ack_i[i] = 1'b0;
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && wbs_ack_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_ack: got ack with data %h want no ack", wbs_dat_o);
      end else begin
        check("ack_data", wbs_dat_o, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic [31:0] exp_dat, input int exp_lat,
                      input int exp_stb, input string name);
    int lat;
    int stb;
    bit got;
    exp_q.push_back(exp_dat);
    exp_last = exp_dat;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    lat = 0; stb = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bnk_stb_o != '0) begin
        if (stb == 0) begin
          cap_adr = bnk_adr_o; cap_dat = bnk_dat_o; cap_sel = bnk_sel_o; cap_we = bnk_we_o;
        end
        stb++;
      end
      if (wbs_ack_o === 1'b1) got = 1'b1;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_ack_wait: got no ack in 40 cycles want ack", name);
      void'(exp_q.pop_back());
    end else begin
      check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    end
    check({name, "_stb_cycles"}, 32'(stb), 32'(exp_stb));
  endtask

  task automatic noack(input logic [31:0] adr, input string name);
    int acks;
    int stb;
    acks = 0; stb = 0;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = adr; wbs_sel_i = 4'hF;
    repeat (6) begin
      @(negedge clk);
      if (wbs_ack_o === 1'b1) acks++;
      if (bnk_stb_o != '0) stb++;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    check({name, "_acks"}, 32'(acks), 32'd0);
    check({name, "_stb"}, 32'(stb), 32'd0);
    check({name, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ack"}, 32'(wbs_ack_o), 32'd0);
    check({name, "_dat"}, wbs_dat_o, 32'd0);
    check({name, "_cyc"}, 32'(bnk_cyc_o), 32'd0);
    check({name, "_stb"}, 32'(bnk_stb_o), 32'd0);
    check({name, "_bwe"}, 32'(bnk_we_o), 32'd0);
    check({name, "_bsel"}, 32'(bnk_sel_o), 32'd0);
    check({name, "_badr"}, bnk_adr_o, 32'd0);
    check({name, "_bdat"}, bnk_dat_o, 32'd0);
    check({name, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    int acks;
    int stb;
    for (int i = 0; i < NB; i++) begin
      dly[i] = 0; bcnt[i] = 0; bdat[i] = 32'hA5A5_0000 + 32'(i);
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    dly[2] = 3; bdat[2] = 32'h1234_5678;
    xfer(1'b0, 32'h3000_2010, 32'h0, 4'hF, 32'h1234_5678, 4, 3, "bank2_rd");
    check("bank2_rd_adr", cap_adr, 32'h10);
    check("bank2_rd_we", 32'(cap_we), 32'd0);
    xfer(1'b0, 32'h3000_F008, 32'h0, 4'hF, 32'h1, 1, 0, "txn_one");

    dly[0] = 1;
    xfer(1'b1, 32'h3000_0024, 32'hDEAD_BEEF, 4'h3, exp_last, 2, 1, "bank0_wr");
    check("bank0_wr_adr", cap_adr, 32'h24);
    check("bank0_wr_dat", cap_dat, 32'hDEAD_BEEF);
    check("bank0_wr_sel", 32'(cap_sel), 32'h3);
    check("bank0_wr_we", 32'(cap_we), 32'd1);

    xfer(1'b0, 32'h3000_1000, 32'h0, 4'hF, ERR, 9, 8, "bank1_timeout");
    xfer(1'b0, 32'h3000_F004, 32'h0, 4'hF, 32'h0000_0101, 1, 0, "status_to");

    xfer(1'b1, 32'h3000_F000, 32'hE, 4'hF, exp_last, 1, 0, "ctrl_wr_e");
    xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, ERR, 1, 0, "bank0_disabled");
    xfer(1'b0, 32'h3000_F004, 32'h0, 4'hF, 32'h0000_0003, 1, 0, "status_dec");
    xfer(1'b0, 32'h3000_F00C, 32'h0, 4'hF, 32'h5831_040C, 1, 0, "id");
    xfer(1'b1, 32'h3000_F004, 32'h3, 4'hF, exp_last, 1, 0, "status_w1c");
    xfer(1'b0, 32'h3000_F004, 32'h0, 4'hF, 32'h0, 1, 0, "status_clr");

    xfer(1'b1, 32'h3000_F000, 32'hF, 4'h1, exp_last, 1, 0, "ctrl_wr_partsel");
    xfer(1'b0, 32'h3000_F000, 32'h0, 4'hF, 32'hE, 1, 0, "ctrl_unchanged");
    xfer(1'b1, 32'h3000_F000, 32'hF, 4'hF, exp_last, 1, 0, "ctrl_wr_f");
    xfer(1'b0, 32'h3000_F000, 32'h0, 4'hF, 32'hF, 1, 0, "ctrl_f");

    xfer(1'b0, 32'h3000_5000, 32'h0, 4'hF, ERR, 1, 0, "decode_idx5");
    xfer(1'b0, 32'h3000_F004, 32'h0, 4'hF, 32'h0000_0502, 1, 0, "status_idx5");
    xfer(1'b1, 32'h3000_F004, 32'h3, 4'hF, exp_last, 1, 0, "status_w1c2");

    xfer(1'b0, 32'h3000_F008, 32'h0, 4'hF, 32'h2, 1, 0, "txn_two");
    xfer(1'b1, 32'h3000_F008, 32'h1234, 4'hF, exp_last, 1, 0, "txn_wr");
    xfer(1'b0, 32'h3000_F008, 32'h0, 4'hF, 32'h0, 1, 0, "txn_cleared");

    noack(32'h4000_2010, "miss");

    // host abort while bank 3 is busy
    dly[3] = 5; bdat[3] = 32'hCAFE_0003;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_3000; wbs_sel_i = 4'hF;
    repeat (2) @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    acks = 0; stb = 0;
    repeat (10) begin
      @(negedge clk);
      if (wbs_ack_o === 1'b1) acks++;
      if (bnk_stb_o[3]) stb++;
    end
    check("abort_acks", 32'(acks), 32'd0);
    check("abort_stb_after_drop", 32'(stb), 32'd3);
    check("abort_state", 32'(dbg_state), 32'd0);
    exp_last = 32'hCAFE_0003;

    dly[2] = 2; bdat[2] = 32'h0BAD_F00D;
    xfer(1'b0, 32'h3000_2004, 32'h0, 4'hF, 32'h0BAD_F00D, 3, 2, "post_abort_rd");
    check("post_abort_adr", cap_adr, 32'h4);
    xfer(1'b0, 32'h3000_F008, 32'h0, 4'hF, 32'h2, 1, 0, "txn_after_abort");

    // reset while bank 0 is being forwarded
    dly[0] = 0;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 32'h3000_0040; wbs_dat_i = 32'h5555_AAAA; wbs_sel_i = 4'hF;
    repeat (2) @(negedge clk);
    check("prerst_stb", 32'(bnk_stb_o), 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midfwd_rst");
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_last = '0;
    xfer(1'b0, 32'h3000_F000, 32'h0, 4'hF, 32'hF, 1, 0, "ctrl_after_rst");
    xfer(1'b0, 32'h3000_F008, 32'h0, 4'hF, 32'h0, 1, 0, "txn_after_rst");
    xfer(1'b0, 32'h3000_F004, 32'h0, 4'hF, 32'h0, 1, 0, "status_after_rst");

    repeat (3) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/neuromorphic_x1_wb_bank_router.md
NEUROMORPHIC_X1_WB_BANK_ROUTER -- requirements
Module: neuromorphic_x1_wb_bank_router

Interface
REQ-001 Parameter NUM_BANKS, default 4, number of X1 core banks behind the router; legal range 1..8.
REQ-002 Parameter BANK_AW, default 12, byte-address bits per bank window.
REQ-003 Parameter BASE_ADDR, default 32'h3000_0000, router base; bits [BANK_AW+3:0] SHALL be zero.
REQ-004 Parameter TIMEOUT_CYC, default 255, bank-ack wait limit in cycles; legal range 1..65535.
REQ-005 Parameter ERR_WORD, default 32'hBADC_0FFE, read data returned on any error response.
REQ-006 wb_clk_i  in  1  sole clock; all state on rising edge.
REQ-007 wb_rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-008 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  host Wishbone classic controls.
REQ-009 wbs_sel_i  in  4; wbs_adr_i  in  32; wbs_dat_i  in  32  host select, address, write data.
REQ-010 wbs_dat_o  out  32; wbs_ack_o  out  1  host read data, one-cycle acknowledge.
REQ-011 bnk_cyc_o, bnk_stb_o  out  NUM_BANKS each  per-bank cycle/strobe, at most one bit set.
REQ-012 bnk_we_o  out  1; bnk_sel_o  out  4; bnk_adr_o  out  32; bnk_dat_o  out  32  shared bank request fields, registered.
REQ-013 bnk_dat_i  in  32*NUM_BANKS; bnk_ack_i  in  NUM_BANKS  per-bank read data and ack; bank i occupies bits [32i+31:32i].

Function
REQ-014 Decode: hit when wbs_adr_i[31:BANK_AW+4] equals BASE_ADDR[31:BANK_AW+4]; idx = wbs_adr_i[BANK_AW+3:BANK_AW].
REQ-015 Hit with idx < NUM_BANKS and CTRL enable bit idx set: bank target; idx = 15: CSR target; any other hit: decode error; no hit: request ignored, no ack, no state change.
REQ-016 FSM states IDLE, FWD, RESP; reset state IDLE.
REQ-017 IDLE: request present when wbs_cyc_i & wbs_stb_i & hit; bank target -> FWD; CSR target or decode error -> RESP; otherwise stay.
REQ-018 On IDLE->FWD, capture we/sel/adr/dat into bnk_* outputs; bnk_adr_o = {BANK_AW-bit offset zero-extended}; assert bnk_cyc_o[idx] and bnk_stb_o[idx] from the next cycle.
REQ-019 FWD: hold bank request stable; on bnk_ack_i[idx] high, latch bnk_dat_i slice into wbs_dat_o (reads only), drop bnk_cyc_o/bnk_stb_o, increment TXN_CNT, go RESP.
REQ-020 FWD timeout: 16-bit counter cleared on entry; when it reaches TIMEOUT_CYC without ack, drop bank strobe, wbs_dat_o = ERR_WORD, set STATUS.timeout, STATUS.bank = idx, go RESP.
REQ-021 RESP: wbs_ack_o high exactly one cycle, then IDLE; acks of non-selected banks and late acks outside FWD SHALL be ignored.
REQ-022 Latency: CSR/decode-error ack in cycle T+1 after request cycle T; bank ack in cycle after bnk_ack_i sampled high.
REQ-023 Host abort: wbs_cyc_i low during FWD sets abort flag; bank transaction completes or times out normally, then FSM goes IDLE without wbs_ack_o; flag cleared in IDLE.
REQ-024 Decode error: wbs_dat_o = ERR_WORD, STATUS.decode set, STATUS.bank = idx[2:0].
REQ-025 CSR map by wbs_adr_i[3:2]: 0 CTRL [NUM_BANKS-1:0] bank enables, RW; 1 STATUS [0] timeout, [1] decode, [10:8] bank, W1C on bits 1:0; 2 TXN_CNT 32-bit wrapping, any write clears; 3 ID read-only {16'h5831, 8'(NUM_BANKS), 8'(BANK_AW)}.
REQ-026 CSR writes take effect only when wbs_sel_i = 4'hF; otherwise acked, no effect; CSR reads return value in RESP.
REQ-027 Simultaneous STATUS W1C and new error in same cycle: set wins; TXN_CNT write and increment same cycle: clear wins.
REQ-028 wbs_dat_o holds last value between acks; write acks leave it unchanged.

Reset
REQ-029 wb_rst_ni low asynchronously forces: FSM IDLE, wbs_ack_o 0, wbs_dat_o 0, all bnk_cyc_o/bnk_stb_o 0, bnk_we_o 0, bnk_sel_o 0, bnk_adr_o 0, bnk_dat_o 0, CTRL all ones, STATUS 0, TXN_CNT 0, timeout counter 0, abort flag 0.
REQ-030 Reset mid-FWD drops bank strobe immediately; no host ack issued; release synchronised to wb_clk_i edge.

Verification
REQ-031 Read bank 2 at 32'h3000_2010, bank acks after 3 cycles with 32'h1234_5678 -> bnk_adr_o 32'h10, wbs_ack_o one cycle after bank ack, wbs_dat_o 32'h1234_5678, TXN_CNT 1.
REQ-032 Bank 1 never acks, TIMEOUT_CYC 8 -> strobe dropped after 8 FWD cycles, wbs_dat_o 32'hBADC_0FFE, STATUS 32'h0000_0101.
REQ-033 Write CTRL 32'h0000_000E, then read bank 0 -> ack at T+1, ERR_WORD, STATUS.decode 1, bnk_stb_o stays 0.
REQ-034 Read 32'h3000_F00C -> 32'h5831_040C at T+1; write 32'h3 to STATUS -> STATUS 0.
REQ-035 Drop wbs_cyc_i during FWD, bank acks later -> no wbs_ack_o, FSM IDLE, next request serviced normally.
REQ-036 Assert wb_rst_ni low mid-FWD -> all outputs at reset values within same cycle, CTRL 32'hF.
